pos_update_ctl: RTL and testbench

Frame-synchronous controller that shares the registered cursor-position path between two requesters (mouse decoder and an auto-motion/animation source). It arbitrates round-robin, applies at most one position update per frame at the start of vertical blanking, and drives the registered `xpos_out`/`ypos_out` consumed by the draw pipeline. This guarantees that a frame never sees a mid-frame position change.

---
 rtl/pos_update_pkg.sv | 15 +
 rtl/rr_arb2.sv | 31 +++
 rtl/pos_update_ctl.sv | 119 +++++++++++
 tb/tb_pos_update_ctl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pos_update_pkg.sv
// rtl/pos_update_pkg.sv - shared FSM state type and default sizes for pos_update_ctl
package pos_update_pkg;

    localparam int POS_W_DEF = 12;
    localparam int H_MAX_DEF = 800;
    localparam int V_MAX_DEF = 600;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        UPDATE  = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter; pointer moves past the winner on adv
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    logic r_ptr;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer always points at the requester that did not just win
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (adv && (gnt != 2'b00)) begin
            r_ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/pos_update_ctl.sv
// rtl/pos_update_ctl.sv - frame-synchronous cursor position update controller, one update per vblank
// Optional clamping to the active area when POS_UPDATE_CTL_CLAMP_EN is defined.
module pos_update_ctl
    import pos_update_pkg::*;
#(
    parameter int POS_W = POS_W_DEF,
    parameter int H_MAX = H_MAX_DEF,
    parameter int V_MAX = V_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vblank,
    input  logic             req0,
    input  logic [POS_W-1:0] xpos0,
    input  logic [POS_W-1:0] ypos0,
    input  logic             req1,
    input  logic [POS_W-1:0] xpos1,
    input  logic [POS_W-1:0] ypos1,
    output logic             ack0,
    output logic             ack1,
    output logic [POS_W-1:0] xpos_out,
    output logic [POS_W-1:0] ypos_out,
    output logic             upd,
    output logic             grant_id
);

`ifdef POS_UPDATE_CTL_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    // With clamping off the limit is all-ones, so the compare never fires
    localparam logic [POS_W-1:0] X_LIM = CLAMP_EN ? POS_W'(H_MAX - 1) : {POS_W{1'b1}};
    localparam logic [POS_W-1:0] Y_LIM = CLAMP_EN ? POS_W'(V_MAX - 1) : {POS_W{1'b1}};

    state_t           r_state;
    logic             r_vblank_d;
    logic             w_vb_rise;
    logic             w_any_req;
    logic             w_load;
    logic [1:0]       w_gnt;
    logic [POS_W-1:0] w_sel_x;
    logic [POS_W-1:0] w_sel_y;
    logic [POS_W-1:0] w_ld_x;
    logic [POS_W-1:0] w_ld_y;

    assign w_vb_rise = vblank & ~r_vblank_d;
    assign w_any_req = req0 | req1;
    assign w_load    = w_vb_rise & w_any_req & ((r_state == IDLE) || (r_state == ARMED));

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({req1, req0}),
        .adv (w_load),
        .gnt (w_gnt)
    );

    assign w_sel_x = w_gnt[1] ? xpos1 : xpos0;
    assign w_sel_y = w_gnt[1] ? ypos1 : ypos0;
    assign w_ld_x  = (w_sel_x > X_LIM) ? X_LIM : w_sel_x;
    assign w_ld_y  = (w_sel_y > Y_LIM) ? Y_LIM : w_sel_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_vblank_d <= 1'b0;
            xpos_out   <= '0;
            ypos_out   <= '0;
            upd        <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            grant_id   <= 1'b0;
        end else begin
            r_vblank_d <= vblank;
            upd        <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state <= w_vb_rise ? UPDATE : ARMED;
                    end
                end
                ARMED: begin
                    if (!w_any_req) begin
                        r_state <= IDLE;
                    end else if (w_vb_rise) begin
                        r_state <= UPDATE;
                    end
                end
                UPDATE: begin
                    r_state <= HOLDOFF;
                end
                HOLDOFF: begin
                    // Stay here for the rest of this blanking interval
                    if (!vblank) begin
                        r_state <= w_any_req ? ARMED : IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_load) begin
                xpos_out <= w_ld_x;
                ypos_out <= w_ld_y;
                upd      <= 1'b1;
                ack0     <= w_gnt[0];
                ack1     <= w_gnt[1];
                grant_id <= w_gnt[1];
            end
        end
    end

endmodule

// File: tb/tb_pos_update_ctl.sv
// tb/tb_pos_update_ctl.sv - scoreboard bench for pos_update_ctl
module tb_pos_update_ctl;

    typedef struct {
        bit          a0;
        bit          a1;
        logic [11:0] x;
        logic [11:0] y;
        bit          gid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vblank = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [11:0] xpos0 = '0;
    logic [11:0] ypos0 = '0;
    logic [11:0] xpos1 = '0;
    logic [11:0] ypos1 = '0;
    logic        ack0;
    logic        ack1;
    logic [11:0] xpos_out;
    logic [11:0] ypos_out;
    logic        upd;
    logic        grant_id;

    int   vectors = 0;
    int   miscompares = 0;
    bit   tb_ptr = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    pos_update_ctl dut (
        .clk      (clk),
        .rst      (rst),
        .vblank   (vblank),
        .req0     (req0),
        .xpos0    (xpos0),
        .ypos0    (ypos0),
        .req1     (req1),
        .xpos1    (xpos1),
        .ypos1    (ypos1),
        .ack0     (ack0),
        .ack1     (ack1),
        .xpos_out (xpos_out),
        .ypos_out (ypos_out),
        .upd      (upd),
        .grant_id (grant_id)
    );

    // Model of the expected grant and loaded value at a vblank rise
    task automatic push_expect();
        exp_t e;
        bit   g;
        if (req0 && req1) g = tb_ptr;
        else              g = req1;
        tb_ptr = ~g;
        e.a0  = ~g;
        e.a1  = g;
        e.gid = g;
        e.x   = g ? xpos1 : xpos0;
        e.y   = g ? ypos1 : ypos0;
`ifdef POS_UPDATE_CTL_CLAMP_EN
        if (e.x > 12'd799) e.x = 12'd799;
        if (e.y > 12'd599) e.y = 12'd599;
`endif
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vblank = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        tb_ptr = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && upd) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_upd: got upd=1 x=%0d y=%0d ack0=%0b ack1=%0b, expected no update",
                         xpos_out, ypos_out, ack0, ack1);
            end else begin
                mon_e = sb.pop_front();
                vectors += 5;
                if (ack0 !== mon_e.a0) begin
                    miscompares++;
                    $display("FAIL ack0: got %0b expected %0b", ack0, mon_e.a0);
                end
                if (ack1 !== mon_e.a1) begin
                    miscompares++;
                    $display("FAIL ack1: got %0b expected %0b", ack1, mon_e.a1);
                end
                if (xpos_out !== mon_e.x) begin
                    miscompares++;
                    $display("FAIL xpos_out: got %0d expected %0d", xpos_out, mon_e.x);
                end
                if (ypos_out !== mon_e.y) begin
                    miscompares++;
                    $display("FAIL ypos_out: got %0d expected %0d", ypos_out, mon_e.y);
                end
                if (grant_id !== mon_e.gid) begin
                    miscompares++;
                    $display("FAIL grant_id: got %0b expected %0b", grant_id, mon_e.gid);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors += 6;
        if (xpos_out !== 12'd0) begin miscompares++; $display("FAIL reset_xpos: got %0d expected 0", xpos_out); end
        if (ypos_out !== 12'd0) begin miscompares++; $display("FAIL reset_ypos: got %0d expected 0", ypos_out); end
        if (upd !== 1'b0)       begin miscompares++; $display("FAIL reset_upd: got %0b expected 0", upd); end
        if (ack0 !== 1'b0)      begin miscompares++; $display("FAIL reset_ack0: got %0b expected 0", ack0); end
        if (ack1 !== 1'b0)      begin miscompares++; $display("FAIL reset_ack1: got %0b expected 0", ack1); end
        if (grant_id !== 1'b0)  begin miscompares++; $display("FAIL reset_grant: got %0b expected 0", grant_id); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        req0 = 1'b1; xpos0 = 12'd100; ypos0 = 12'd50;
        repeat (3) @(negedge clk);
        vblank = 1'b1;
        push_expect();
        @(negedge clk);
        vectors++;
        if (upd !== 1'b1) begin miscompares++; $display("FAIL basic_upd_k1: got %0b expected 1", upd); end
        @(negedge clk);
        vectors += 3;
        if (upd !== 1'b0)  begin miscompares++; $display("FAIL basic_upd_k2: got %0b expected 0", upd); end
        if (ack0 !== 1'b0) begin miscompares++; $display("FAIL basic_ack0_k2: got %0b expected 0", ack0); end
        if (xpos_out !== 12'd100) begin miscompares++; $display("FAIL basic_hold_x: got %0d expected 100", xpos_out); end
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        vblank = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL basic_pending: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_alternate();
        do_reset();
        req0 = 1'b1; xpos0 = 12'd10; ypos0 = 12'd10;
        req1 = 1'b1; xpos1 = 12'd20; ypos1 = 12'd20;
        for (int f = 0; f < 4; f++) begin
            repeat (2) @(negedge clk);
            vblank = 1'b1;
            push_expect();
            @(negedge clk);
            vectors++;
            if (grant_id !== f[0]) begin
                miscompares++;
                $display("FAIL alt_grant_f%0d: got %0b expected %0b", f, grant_id, f[0]);
            end
            repeat (2) @(negedge clk);
            vblank = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL alt_pending: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_drop();
        int n_upd = 0;
        int n_ack = 0;
        do_reset();
        req1 = 1'b1; xpos1 = 12'd55; ypos1 = 12'd66;
        repeat (2) @(negedge clk);
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        vblank = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (upd)  n_upd++;
            if (ack1) n_ack++;
        end
        vblank = 1'b0;
        vectors += 4;
        if (n_upd != 0) begin miscompares++; $display("FAIL drop_upd: got %0d expected 0", n_upd); end
        if (n_ack != 0) begin miscompares++; $display("FAIL drop_ack1: got %0d expected 0", n_ack); end
        if (xpos_out !== 12'd0) begin miscompares++; $display("FAIL drop_x: got %0d expected 0", xpos_out); end
        if (ypos_out !== 12'd0) begin miscompares++; $display("FAIL drop_y: got %0d expected 0", ypos_out); end
    endtask

    task automatic test_long_vblank();
        int n_upd = 0;
        do_reset();
        req0 = 1'b1; xpos0 = 12'd7; ypos0 = 12'd3;
        repeat (2) @(negedge clk);
        vblank = 1'b1;
        push_expect();
        repeat (500) begin
            @(negedge clk);
            if (upd) n_upd++;
        end
        vectors++;
        if (n_upd != 1) begin miscompares++; $display("FAIL long_one_upd: got %0d expected 1", n_upd); end
        vblank = 1'b0;
        n_upd = 0;
        repeat (4) begin
            @(negedge clk);
            if (upd) n_upd++;
        end
        vectors++;
        if (n_upd != 0) begin miscompares++; $display("FAIL long_low_upd: got %0d expected 0", n_upd); end
        vblank = 1'b1;
        push_expect();
        repeat (3) begin
            @(negedge clk);
            if (upd) n_upd++;
        end
        vblank = 1'b0;
        req0 = 1'b0;
        #1;
        vectors += 2;
        if (n_upd != 1)     begin miscompares++; $display("FAIL long_second_upd: got %0d expected 1", n_upd); end
        if (sb.size() != 0) begin miscompares++; $display("FAIL long_pending: got %0d expected 0", sb.size()); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clamp();
        logic [11:0] ex;
        logic [11:0] ey;
`ifdef POS_UPDATE_CTL_CLAMP_EN
        ex = 12'd799; ey = 12'd599;
`else
        ex = 12'd900; ey = 12'd4095;
`endif
        do_reset();
        req0 = 1'b1; xpos0 = 12'd900; ypos0 = 12'd4095;
        repeat (2) @(negedge clk);
        vblank = 1'b1;
        push_expect();
        @(negedge clk);
        vectors += 2;
        if (xpos_out !== ex) begin miscompares++; $display("FAIL clamp_x: got %0d expected %0d", xpos_out, ex); end
        if (ypos_out !== ey) begin miscompares++; $display("FAIL clamp_y: got %0d expected %0d", ypos_out, ey); end
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        vblank = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_update();
        do_reset();
        req0 = 1'b1; xpos0 = 12'd123; ypos0 = 12'd45;
        repeat (2) @(negedge clk);
        vblank = 1'b1;
        push_expect();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        vectors += 4;
        if (xpos_out !== 12'd0) begin miscompares++; $display("FAIL rstmid_x: got %0d expected 0", xpos_out); end
        if (ypos_out !== 12'd0) begin miscompares++; $display("FAIL rstmid_y: got %0d expected 0", ypos_out); end
        if (ack0 !== 1'b0)      begin miscompares++; $display("FAIL rstmid_ack0: got %0b expected 0", ack0); end
        if (upd !== 1'b0)       begin miscompares++; $display("FAIL rstmid_upd: got %0b expected 0", upd); end
        // vblank still high at release, so the first cycle out of reset is a rise
        tb_ptr = 1'b0;
        push_expect();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (upd !== 1'b1) begin miscompares++; $display("FAIL rstmid_reupd: got %0b expected 1", upd); end
        @(negedge clk);
        vblank = 1'b0;
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL rstmid_pending: got %0d expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alternate();
        test_drop();
        test_long_vblank();
        test_clamp();
        test_reset_mid_update();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
